mdbrot_view_ctrl: RTL and testbench

//  Upstream of the escape-time renderer. Holds the complex-plane view window (xmin/xmax/ymin/ymax),

---
 rtl/mdbrot_pkg.sv | 35 +++
 rtl/mdbrot_view_ctrl_seq_udiv.sv | 68 ++++++
 rtl/mdbrot_view_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mdbrot_view_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdbrot_pkg.sv
// Shared constants and types for the Mandelbrot view controller.
// Coordinates are signed Q4.16 (1.0 = 20'h10000); scales are unsigned Q4.16.
package mdbrot_pkg;

  localparam int Q_W = 20;

  localparam logic [Q_W-1:0] DEF_XMIN     = 20'hE0000;
  localparam logic [Q_W-1:0] DEF_XMAX     = 20'h10000;
  localparam logic [Q_W-1:0] DEF_YMIN     = 20'hEE000;
  localparam logic [Q_W-1:0] DEF_YMAX     = 20'h12000;
  localparam logic [Q_W-1:0] LIM_DEF      = 20'h40000;
  localparam logic [Q_W-1:0] MIN_SPAN_DEF = 20'h00200;

  typedef enum logic [2:0] {
    CMD_REDRAW   = 3'd0,
    CMD_ZOOM_IN  = 3'd1,
    CMD_ZOOM_OUT = 3'd2,
    CMD_LEFT     = 3'd3,
    CMD_RIGHT    = 3'd4,
    CMD_UP       = 3'd5,
    CMD_DOWN     = 3'd6,
    CMD_RESET    = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_SCALE_X = 3'd1,
    ST_SCALE_Y = 3'd2,
    ST_START   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_IDLE    = 3'd5,
    ST_APPLY   = 3'd6
  } view_state_e;

endpackage

// File: rtl/mdbrot_view_ctrl_seq_udiv.sv
// Restoring unsigned divider: one quotient bit per cycle, go loads, done flags
// the final step (quotient valid combinationally in that same cycle).
module seq_udiv #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [W:0]    shifted_s, diff_s;
  logic          ge_s;
  logic [W-1:0]  rem_n, quo_n;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted_s = {rem_q, quo_q[W-1]};
    diff_s    = shifted_s - {1'b0, dvs_q};
    ge_s      = ~diff_s[W];
    if (ge_s) begin
      rem_n = diff_s[W-1:0];
    end else begin
      rem_n = shifted_s[W-1:0];
    end
    quo_n = {quo_q[W-2:0], ge_s};
  end

  // Divider state: load on go, iterate W times.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (go && !busy_q) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= CNT_LOAD;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= rem_n;
      quo_q  <= quo_n;
      cnt_q  <= cnt_q - CNT_ONE;
      busy_q <= (cnt_q != CNT_ONE);
    end else begin
      busy_q <= 1'b0;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CNT_ONE);
  assign quotient = quo_n;

endmodule

// File: rtl/mdbrot_view_ctrl.sv
// View-window controller: applies zoom/pan/reset commands, derives per-pixel
// scales with a shared sequential divider, then launches and waits on a render.
module mdbrot_view_ctrl
  import mdbrot_pkg::*;
#(
  parameter int           W        = Q_W,
  parameter int           H_RES    = 160,
  parameter int           V_RES    = 120,
  parameter logic [12:0]  MAX_ITER = 13'd256,
  parameter logic [W-1:0] MIN_SPAN = MIN_SPAN_DEF,
  parameter logic [W-1:0] LIM      = LIM_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  input  logic [2:0]   cmd,
  output logic         cmd_ready,
  output logic         cmd_err,
  input  logic         render_done,
  output logic         start,
  output logic         busy,
  output logic [W-1:0] xmin,
  output logic [W-1:0] xmax,
  output logic [W-1:0] ymin,
  output logic [W-1:0] ymax,
  output logic [W-1:0] Xscale,
  output logic [W-1:0] Yscale,
  output logic [12:0]  max_iter
);

  localparam int EW = W + 2;

  function automatic logic signed [EW-1:0] sx(input logic [W-1:0] v);
    return $signed({{2{v[W-1]}}, v});
  endfunction

  function automatic logic signed [EW-1:0] zx(input logic [W-1:0] v);
    return $signed({2'b00, v});
  endfunction

  function automatic logic in_lim(input logic signed [EW-1:0] v);
    return (v >= -zx(LIM)) && (v <= zx(LIM));
  endfunction

  logic [2:0]   state_q, state_d;
  logic [2:0]   cmd_q;
  logic [W-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
  logic [W-1:0] xmin_d, xmax_d, ymin_d, ymax_d;
  logic [W-1:0] xscale_q, yscale_q;
  logic         start_q, busy_q, ready_q, err_q;

  logic [W-1:0] span_x_s, span_y_s;
  logic signed [EW-1:0] nxmin_s, nxmax_s, nymin_s, nymax_s;
  logic         legal_s, range_ok_s, span_ok_s;
  logic         div_go_s, div_busy_s, div_done_s, div_sel_y_s;
  logic [W-1:0] div_q_s;

  assign span_x_s = xmax_q - xmin_q;
  assign span_y_s = ymax_q - ymin_q;

  // Candidate window for the latched command; extra headroom bits keep the
  // limit test honest when a bound would wrap the Q4.16 range.
  always_comb begin
    nxmin_s = sx(xmin_q);
    nxmax_s = sx(xmax_q);
    nymin_s = sx(ymin_q);
    nymax_s = sx(ymax_q);
    case (cmd_q)
      CMD_ZOOM_IN: begin
        nxmin_s = sx(xmin_q) + zx(span_x_s >> 2);
        nxmax_s = sx(xmax_q) - zx(span_x_s >> 2);
        nymin_s = sx(ymin_q) + zx(span_y_s >> 2);
        nymax_s = sx(ymax_q) - zx(span_y_s >> 2);
      end
      CMD_ZOOM_OUT: begin
        nxmin_s = sx(xmin_q) - zx(span_x_s >> 1);
        nxmax_s = sx(xmax_q) + zx(span_x_s >> 1);
        nymin_s = sx(ymin_q) - zx(span_y_s >> 1);
        nymax_s = sx(ymax_q) + zx(span_y_s >> 1);
      end
      CMD_LEFT: begin
        nxmin_s = sx(xmin_q) - zx(span_x_s >> 3);
        nxmax_s = sx(xmax_q) - zx(span_x_s >> 3);
      end
      CMD_RIGHT: begin
        nxmin_s = sx(xmin_q) + zx(span_x_s >> 3);
        nxmax_s = sx(xmax_q) + zx(span_x_s >> 3);
      end
      CMD_UP: begin
        nymin_s = sx(ymin_q) - zx(span_y_s >> 3);
        nymax_s = sx(ymax_q) - zx(span_y_s >> 3);
      end
      CMD_DOWN: begin
        nymin_s = sx(ymin_q) + zx(span_y_s >> 3);
        nymax_s = sx(ymax_q) + zx(span_y_s >> 3);
      end
      CMD_RESET: begin
        nxmin_s = sx(DEF_XMIN);
        nxmax_s = sx(DEF_XMAX);
        nymin_s = sx(DEF_YMIN);
        nymax_s = sx(DEF_YMAX);
      end
      default: begin
        nxmin_s = sx(xmin_q);
        nxmax_s = sx(xmax_q);
        nymin_s = sx(ymin_q);
        nymax_s = sx(ymax_q);
      end
    endcase
    range_ok_s = in_lim(nxmin_s) && in_lim(nxmax_s) && in_lim(nymin_s) && in_lim(nymax_s);
    span_ok_s  = ((nxmax_s - nxmin_s) >= zx(MIN_SPAN)) && ((nymax_s - nymin_s) >= zx(MIN_SPAN));
    if (cmd_q == CMD_ZOOM_IN) begin
      legal_s = span_ok_s;
    end else if ((cmd_q == CMD_REDRAW) || (cmd_q == CMD_RESET)) begin
      legal_s = 1'b1;
    end else begin
      legal_s = range_ok_s;
    end
  end

  // Frame sequencing and window commit.
  always_comb begin
    state_d = state_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    case (state_q)
      ST_INIT:    state_d = ST_SCALE_X;
      ST_SCALE_X: if (div_done_s) state_d = ST_SCALE_Y; else state_d = ST_SCALE_X;
      ST_SCALE_Y: if (div_done_s) state_d = ST_START; else state_d = ST_SCALE_Y;
      ST_START:   state_d = ST_WAIT;
      ST_WAIT:    if (render_done) state_d = ST_IDLE; else state_d = ST_WAIT;
      ST_IDLE:    if (cmd_valid) state_d = ST_APPLY; else state_d = ST_IDLE;
      ST_APPLY: begin
        if (legal_s) begin
          state_d = ST_SCALE_X;
          xmin_d  = nxmin_s[W-1:0];
          xmax_d  = nxmax_s[W-1:0];
          ymin_d  = nymin_s[W-1:0];
          ymax_d  = nymax_s[W-1:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      default:    state_d = ST_INIT;
    endcase
  end

  assign div_sel_y_s = (state_q == ST_SCALE_Y);
  assign div_go_s    = ((state_q == ST_SCALE_X) || div_sel_y_s) && !div_busy_s;

  seq_udiv #(.W(W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .go       (div_go_s),
    .dividend (div_sel_y_s ? span_y_s : span_x_s),
    .divisor  (div_sel_y_s ? W'(V_RES) : W'(H_RES)),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .quotient (div_q_s)
  );

  // Registered state, window, scales and handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_INIT;
      cmd_q    <= CMD_REDRAW;
      xmin_q   <= DEF_XMIN;
      xmax_q   <= DEF_XMAX;
      ymin_q   <= DEF_YMIN;
      ymax_q   <= DEF_YMAX;
      xscale_q <= '0;
      yscale_q <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b1;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= (ready_q && cmd_valid) ? cmd : cmd_q;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymin_q   <= ymin_d;
      ymax_q   <= ymax_d;
      xscale_q <= ((state_q == ST_SCALE_X) && div_done_s) ? div_q_s : xscale_q;
      yscale_q <= ((state_q == ST_SCALE_Y) && div_done_s) ? div_q_s : yscale_q;
      start_q  <= (state_d == ST_START);
      busy_q   <= (state_d != ST_IDLE);
      ready_q  <= (state_d == ST_IDLE);
      err_q    <= (state_q == ST_APPLY) && !legal_s;
    end
  end

  assign cmd_ready = ready_q;
  assign cmd_err   = err_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign xmin      = xmin_q;
  assign xmax      = xmax_q;
  assign ymin      = ymin_q;
  assign ymax      = ymax_q;
  assign Xscale    = xscale_q;
  assign Yscale    = yscale_q;
  assign max_iter  = MAX_ITER;

endmodule

// File: tb/tb_mdbrot_view_ctrl.sv
// Directed bench for mdbrot_view_ctrl: inputs driven and outputs sampled on
// the falling edge; expected windows and scales are hand-computed constants.
module tb_mdbrot_view_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic        render_done = 1'b0;
  logic        cmd_ready, cmd_err, start, busy;
  logic [19:0] xmin, xmax, ymin, ymax, Xscale, Yscale;
  logic [12:0] max_iter;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [79:0] WIN_DEF = {20'hE0000, 20'h10000, 20'hEE000, 20'h12000};

  always #5 clk = ~clk;

  mdbrot_view_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .cmd_err(cmd_err), .render_done(render_done), .start(start), .busy(busy),
    .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
    .Xscale(Xscale), .Yscale(Yscale), .max_iter(max_iter)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (start !== 1'b1 && n < 200);
  endtask

  task automatic finish_render();
    tick();
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
  endtask

  task automatic restore_view();
    int n;
    issue(3'd7);
    wait_start(n);
    n_vec++;
    if ({xmin, xmax, ymin, ymax, Xscale, Yscale} !== {WIN_DEF, 20'd1228, 20'd1228}) begin
      n_miss++;
      $display("FAIL reset_view window %h %h %h %h scales %0d %0d, want defaults, 1228",
               xmin, xmax, ymin, ymax, Xscale, Yscale);
    end
    finish_render();
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({xmin, xmax, ymin, ymax} !== WIN_DEF) begin
      n_miss++; $display("FAIL reset_window got %h %h %h %h", xmin, xmax, ymin, ymax);
    end
    n_vec++;
    if ({Xscale, Yscale, start, cmd_ready, cmd_err, busy, max_iter} !== {40'd0, 4'b0001, 13'd256}) begin
      n_miss++;
      $display("FAIL reset_outputs got Xs %0d Ys %0d start %b rdy %b err %b busy %b mi %0d, want 0 0 0 0 0 1 256",
               Xscale, Yscale, start, cmd_ready, cmd_err, busy, max_iter);
    end
    rst = 1'b1;
    wait_start(n);
    n_vec++;
    if (n !== 43) begin n_miss++; $display("FAIL reset_start_latency got %0d want 43", n); end
    n_vec++;
    if ({Xscale, Yscale} !== {20'd1228, 20'd1228}) begin
      n_miss++; $display("FAIL reset_scales got %0d %0d want 1228 1228", Xscale, Yscale);
    end
    render_done = 1'b1;       // arrives while in START: must be ignored
    tick();
    render_done = 1'b0;
    n_vec++;
    if ({start, busy} !== 2'b01) begin
      n_miss++; $display("FAIL start_pulse_width got start %b busy %b want 0 1", start, busy);
    end
    tick();
    n_vec++;
    if (cmd_ready !== 1'b0) begin
      n_miss++; $display("FAIL early_render_done got cmd_ready %b want 0", cmd_ready);
    end
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    n_vec++;
    if ({cmd_ready, busy} !== 2'b10) begin
      n_miss++; $display("FAIL idle_after_render got rdy %b busy %b want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_zoom_in();
    int n;
    issue(3'd1);
    wait_start(n);
    n_vec++;
    if (n + 1 !== 44) begin n_miss++; $display("FAIL zoom_in_latency got %0d want 44", n + 1); end
    n_vec++;
    if ({xmin, xmax, ymin, ymax} !== {20'hEC000, 20'h04000, 20'hF7000, 20'h09000}) begin
      n_miss++;
      $display("FAIL zoom_in_window got %h %h %h %h want EC000 04000 F7000 09000", xmin, xmax, ymin, ymax);
    end
    n_vec++;
    if ({Xscale, Yscale} !== {20'd614, 20'd614}) begin
      n_miss++; $display("FAIL zoom_in_scales got %0d %0d want 614 614", Xscale, Yscale);
    end
    finish_render();
    restore_view();
  endtask

  task automatic test_pan();
    int n;
    issue(3'd4);
    wait_start(n);
    n_vec++;
    if ({xmin, xmax, ymin, ymax, Xscale, Yscale} !==
        {20'hE6000, 20'h16000, 20'hEE000, 20'h12000, 20'd1228, 20'd1228}) begin
      n_miss++;
      $display("FAIL pan_right got %h %h %h %h %0d %0d want E6000 16000 EE000 12000 1228 1228",
               xmin, xmax, ymin, ymax, Xscale, Yscale);
    end
    finish_render();
    restore_view();
    issue(3'd5);
    wait_start(n);
    n_vec++;
    if ({xmin, xmax, ymin, ymax} !== {20'hE0000, 20'h10000, 20'hE9800, 20'h0D800}) begin
      n_miss++;
      $display("FAIL pan_up got %h %h %h %h want E0000 10000 E9800 0D800", xmin, xmax, ymin, ymax);
    end
    finish_render();
    restore_view();
  endtask

  task automatic test_zoom_out_reject();
    int n;
    int starts;
    issue(3'd2);
    wait_start(n);
    n_vec++;
    if ({xmin, xmax, ymin, ymax, Xscale, Yscale} !==
        {20'hC8000, 20'h28000, 20'hDC000, 20'h24000, 20'd2457, 20'd2457}) begin
      n_miss++;
      $display("FAIL zoom_out_first got %h %h %h %h %0d %0d want C8000 28000 DC000 24000 2457 2457",
               xmin, xmax, ymin, ymax, Xscale, Yscale);
    end
    finish_render();
    issue(3'd2);
    n_vec++;
    if ({cmd_err, busy, cmd_ready} !== 3'b010) begin
      n_miss++; $display("FAIL reject_apply got err %b busy %b rdy %b want 0 1 0", cmd_err, busy, cmd_ready);
    end
    tick();
    n_vec++;
    if ({cmd_err, busy, cmd_ready} !== 3'b101) begin
      n_miss++; $display("FAIL reject_err_pulse got err %b busy %b rdy %b want 1 0 1", cmd_err, busy, cmd_ready);
    end
    starts = 0;
    repeat (60) begin
      tick();
      if (start === 1'b1 || cmd_err === 1'b1) starts++;
    end
    n_vec++;
    if (starts !== 0) begin n_miss++; $display("FAIL reject_quiet got %0d start/err cycles want 0", starts); end
    n_vec++;
    if ({xmin, xmax, ymin, ymax} !== {20'hC8000, 20'h28000, 20'hDC000, 20'h24000}) begin
      n_miss++; $display("FAIL reject_window got %h %h %h %h want C8000 28000 DC000 24000", xmin, xmax, ymin, ymax);
    end
    restore_view();
  endtask

  task automatic test_zoom_in_limit();
    int n;
    int bad_lat;
    bad_lat = 0;
    for (int i = 0; i < 8; i++) begin
      issue(3'd1);
      wait_start(n);
      if (n + 1 != 44) bad_lat++;
      finish_render();
    end
    n_vec++;
    if (bad_lat !== 0) begin n_miss++; $display("FAIL deep_zoom_latency got %0d bad frames want 0", bad_lat); end
    n_vec++;
    if ({xmin, xmax, ymin, ymax, Xscale, Yscale} !==
        {20'hF7E80, 20'hF8180, 20'hFFEE0, 20'h00120, 20'd4, 20'd4}) begin
      n_miss++;
      $display("FAIL deep_zoom got %h %h %h %h %0d %0d want F7E80 F8180 FFEE0 00120 4 4",
               xmin, xmax, ymin, ymax, Xscale, Yscale);
    end
    issue(3'd1);
    tick();
    n_vec++;
    if ({cmd_err, cmd_ready, xmin, xmax} !== {2'b11, 20'hF7E80, 20'hF8180}) begin
      n_miss++; $display("FAIL min_span_reject got err %b rdy %b x %h %h want 1 1 F7E80 F8180",
                         cmd_err, cmd_ready, xmin, xmax);
    end
    restore_view();
  endtask

  task automatic test_busy_hold();
    int n;
    int ready_seen;
    issue(3'd0);
    tick();
    tick();
    cmd = 3'd4;
    cmd_valid = 1'b1;         // held from SCALE_X onward
    ready_seen = 0;
    n = 3;
    while (start !== 1'b1 && n < 200) begin
      if (cmd_ready !== 1'b0) ready_seen++;
      tick();
      n++;
    end
    n_vec++;
    if (n !== 44 || ready_seen !== 0) begin
      n_miss++; $display("FAIL hold_during_scale got latency %0d ready %0d want 44 0", n, ready_seen);
    end
    n_vec++;
    if ({xmin, xmax} !== {20'hE0000, 20'h10000}) begin
      n_miss++; $display("FAIL hold_not_applied got %h %h want E0000 10000", xmin, xmax);
    end
    tick();
    n_vec++;
    if ({cmd_ready, busy} !== 2'b01) begin
      n_miss++; $display("FAIL hold_during_wait got rdy %b busy %b want 0 1", cmd_ready, busy);
    end
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    n_vec++;
    if (cmd_ready !== 1'b1) begin n_miss++; $display("FAIL hold_idle got rdy %b want 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    wait_start(n);
    n_vec++;
    if (n + 1 !== 44 || {xmin, xmax} !== {20'hE6000, 20'h16000}) begin
      n_miss++; $display("FAIL hold_accept got latency %0d x %h %h want 44 E6000 16000", n + 1, xmin, xmax);
    end
    finish_render();
    restore_view();
  endtask

  task automatic test_reset_mid();
    int n;
    issue(3'd1);
    repeat (28) tick();
    rst = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({xmin, xmax, ymin, ymax, Xscale, Yscale} !== {WIN_DEF, 40'd0}) begin
      n_miss++; $display("FAIL mid_reset_window got %h %h %h %h %0d %0d want defaults 0 0",
                         xmin, xmax, ymin, ymax, Xscale, Yscale);
    end
    n_vec++;
    if ({start, busy, cmd_ready} !== 3'b010) begin
      n_miss++; $display("FAIL mid_reset_ctrl got start %b busy %b rdy %b want 0 1 0", start, busy, cmd_ready);
    end
    rst = 1'b1;
    wait_start(n);
    n_vec++;
    if (n !== 43 || {xmin, xmax, Xscale, Yscale} !== {20'hE0000, 20'h10000, 20'd1228, 20'd1228}) begin
      n_miss++; $display("FAIL mid_reset_frame got latency %0d x %h %h scales %0d %0d want 43 E0000 10000 1228 1228",
                         n, xmin, xmax, Xscale, Yscale);
    end
    finish_render();
  endtask

  initial begin
    test_reset();
    test_zoom_in();
    test_pan();
    test_zoom_out_reject();
    test_zoom_in_limit();
    test_busy_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
